// File: rtl/ccd_pkg.sv
// ccd_pkg
//   Shared definitions for the CCD test-pattern source:
//   - ccd_state_e : frame-timing FSM states
//   - MODE_*      : pattern selector values carried on iMode
//   - BAYER_*     : per-colour levels of the flat Bayer pattern
//   - CHECKER_*   : checkerboard levels
//   - COLUMN_WIDTH: default active pixels per line
//   - ccd_state_has_fv(): FRAME_VALID level for a given state
package ccd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VBLANK = 3'd1,
    ST_LEAD   = 3'd2,
    ST_LINE   = 3'd3,
    ST_HBLANK = 3'd4,
    ST_TRAIL  = 3'd5
  } ccd_state_e;

  localparam logic [1:0] MODE_RAMP    = 2'd0;
  localparam logic [1:0] MODE_BAYER   = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_CONST   = 2'd3;

  localparam logic [11:0] BAYER_G = 12'd2048;
  localparam logic [11:0] BAYER_R = 12'd4095;
  localparam logic [11:0] BAYER_B = 12'd0;

  localparam logic [11:0] CHECKER_HI = 12'd4095;
  localparam logic [11:0] CHECKER_LO = 12'd0;

  localparam int COLUMN_WIDTH = 2592;

  // FRAME_VALID is high from the lead-in through the trailer.
  function automatic logic ccd_state_has_fv(input ccd_state_e st);
    return (st == ST_LEAD) || (st == ST_LINE) ||
           (st == ST_HBLANK) || (st == ST_TRAIL);
  endfunction

endpackage

// File: rtl/ccd_pattern_lut.sv
// ccd_pattern_lut
//   Purely combinational pattern generator: maps the frame's pattern mode
//   and the current pixel coordinate to a 12-bit pixel value.
//   Ports:
//     mode      in  2   pattern select (MODE_RAMP/BAYER/CHECKER/CONST)
//     x         in  16  column index within the line
//     y         in  16  line index within the frame
//     const_val in  12  level used by the constant pattern
//     data      out 12  pixel value
module ccd_pattern_lut
  import ccd_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [11:0] const_val,
  output logic [11:0] data
);

  logic [16:0] ramp_sum;
  // Carry bits above the 12-bit pixel are dropped by design (mod 4096).
  logic        unused_ramp_carry;

  assign ramp_sum          = {1'b0, x} + {1'b0, y};
  assign unused_ramp_carry = ^ramp_sum[16:12];

  always_comb begin
    data = '0;
    case (mode)
      MODE_RAMP: begin
        data = ramp_sum[11:0];
      end
      MODE_BAYER: begin
        // {row parity, column parity}: G R on even rows, B G on odd rows.
        case ({y[0], x[0]})
          2'b00:   data = BAYER_G;
          2'b01:   data = BAYER_R;
          2'b10:   data = BAYER_B;
          default: data = BAYER_G;
        endcase
      end
      MODE_CHECKER: begin
        // 16x16-pixel squares.
        data = (x[4] ^ y[4]) ? CHECKER_HI : CHECKER_LO;
      end
      default: begin
        data = const_val;
      end
    endcase
  end

endmodule

// File: rtl/ccd_pattern_source.sv
// ccd_pattern_source
//   Emulates a CCD sensor's parallel output: generates FRAME_VALID /
//   LINE_VALID timing and a selectable 12-bit test pattern, all changing on
//   pixel ticks (every 4th iCLK) so they are stable at the oPIXCLK rising
//   edge.
//   Ports:
//     iCLK          in  1   system clock
//     iRST          in  1   asynchronous active-low reset
//     iEnable       in  1   run frames continuously; low stops after the frame
//     iMode         in  2   pattern select, latched at the start of each frame
//     iConst        in  12  constant-pattern level, latched with iMode
//     oPIXCLK       out 1   pixel clock (iCLK/4)
//     oF_valid      out 1   FRAME_VALID
//     oL_valid      out 1   LINE_VALID
//     oCam_data     out 12  pixel data, zero while LINE_VALID is low
//     oFrame_done   out 1   one-iCLK pulse when a frame's trailer ends
//     oFrame_count  out 16  number of completed frames (wraps)
//   All blanking/lead/trail parameters must be at least 1.
module ccd_pattern_source
  import ccd_pkg::*;
#(
  parameter int ACTIVE_W = COLUMN_WIDTH,
  parameter int ACTIVE_H = 1944,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 64,
  parameter int FV_LEAD  = 4,
  parameter int FV_TRAIL = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEnable,
  input  logic [1:0]  iMode,
  input  logic [11:0] iConst,
  output logic        oPIXCLK,
  output logic        oF_valid,
  output logic        oL_valid,
  output logic [11:0] oCam_data,
  output logic        oFrame_done,
  output logic [15:0] oFrame_count
);

  // Last value of each duration/position counter before the state changes.
  localparam logic [15:0] W_LAST     = 16'(ACTIVE_W - 1);
  localparam logic [15:0] H_LAST     = 16'(ACTIVE_H - 1);
  localparam logic [15:0] HB_LAST    = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST    = 16'(V_BLANK - 1);
  localparam logic [15:0] LEAD_LAST  = 16'(FV_LEAD - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(FV_TRAIL - 1);

  logic [1:0]  div_q,    div_d;
  ccd_state_e  state_q,  state_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [15:0] x_q,      x_d;
  logic [15:0] y_q,      y_d;
  logic [1:0]  mode_q,   mode_d;
  logic [11:0] const_q,  const_d;
  logic        fv_q,     fv_d;
  logic        lv_q,     lv_d;
  logic [11:0] data_q,   data_d;
  logic        done_q,   done_d;
  logic [15:0] fcount_q, fcount_d;

  logic        tick;
  logic [11:0] lut_data;

  assign tick = (div_q == 2'd3);

  // The LUT looks at the coordinate being entered so the registered pixel
  // lines up with the registered LINE_VALID.
  ccd_pattern_lut u_lut (
    .mode      (mode_q),
    .x         (x_d),
    .y         (y_d),
    .const_val (const_q),
    .data      (lut_data)
  );

  // Next-state and next-output logic.
  always_comb begin
    div_d    = div_q + 2'd1;
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    const_d  = const_q;
    fv_d     = fv_q;
    lv_d     = lv_q;
    data_d   = data_q;
    done_d   = 1'b0;
    fcount_d = fcount_q;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (iEnable) begin
            state_d = ST_VBLANK;
            cnt_d   = '0;
          end
        end
        ST_VBLANK: begin
          if (cnt_q == VB_LAST) begin
            state_d = ST_LEAD;
            cnt_d   = '0;
            // Freeze the pattern selection for the whole frame.
            mode_d  = iMode;
            const_d = iConst;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_LEAD: begin
          if (cnt_q == LEAD_LAST) begin
            state_d = ST_LINE;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_LINE: begin
          if (x_q == W_LAST) begin
            cnt_d   = '0;
            state_d = (y_q < H_LAST) ? ST_HBLANK : ST_TRAIL;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
        ST_HBLANK: begin
          if (cnt_q == HB_LAST) begin
            state_d = ST_LINE;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = y_q + 16'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_TRAIL: begin
          if (cnt_q == TRAIL_LAST) begin
            cnt_d    = '0;
            done_d   = 1'b1;
            fcount_d = fcount_q + 16'd1;
            // iEnable is only honoured here, so a frame is never cut short.
            state_d  = iEnable ? ST_VBLANK : ST_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      fv_d   = ccd_state_has_fv(state_d);
      lv_d   = (state_d == ST_LINE);
      data_d = lv_d ? lut_data : 12'd0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      div_q    <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= MODE_RAMP;
      const_q  <= '0;
      fv_q     <= 1'b0;
      lv_q     <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      fcount_q <= '0;
    end else begin
      div_q    <= div_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      const_q  <= const_d;
      fv_q     <= fv_d;
      lv_q     <= lv_d;
      data_q   <= data_d;
      done_q   <= done_d;
      fcount_q <= fcount_d;
    end
  end

  assign oPIXCLK      = div_q[1];
  assign oF_valid     = fv_q;
  assign oL_valid     = lv_q;
  assign oCam_data    = data_q;
  assign oFrame_done  = done_q;
  assign oFrame_count = fcount_q;

endmodule

// File: tb/tb_ccd_pattern_source.sv
module tb_ccd_pattern_source;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int HB     = 2;
  localparam int VB     = 3;
  localparam int LEAD   = 1;
  localparam int TRAIL  = 1;
  localparam int ACT    = H * W + (H - 1) * HB;
  localparam int PERIOD = VB + LEAD + ACT + TRAIL;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iEnable = 1'b0;
  logic [1:0]  iMode = 2'd0;
  logic [11:0] iConst = 12'd0;
  logic        oPIXCLK, oF_valid, oL_valid, oFrame_done;
  logic [11:0] oCam_data;
  logic [15:0] oFrame_count;

  ccd_pattern_source #(
    .ACTIVE_W (W),
    .ACTIVE_H (H),
    .H_BLANK  (HB),
    .V_BLANK  (VB),
    .FV_LEAD  (LEAD),
    .FV_TRAIL (TRAIL)
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iEnable      (iEnable),
    .iMode        (iMode),
    .iConst       (iConst),
    .oPIXCLK      (oPIXCLK),
    .oF_valid     (oF_valid),
    .oL_valid     (oL_valid),
    .oCam_data    (oCam_data),
    .oFrame_done  (oFrame_done),
    .oFrame_count (oFrame_count)
  );

  always #5 iCLK = ~iCLK;

  int tests = 0;
  int fails = 0;

  // Reference model: a frame is a sequence of PERIOD tick positions, the
  // outputs at each position follow from plain arithmetic on the position.
  int m_edges;
  bit m_run;
  int m_pos;
  int m_mode;
  int m_const;
  int m_fcount;
  bit m_done;

  logic [11:0] cap[$];

  typedef struct packed {
    logic [1:0]        mode;
    logic [11:0]       konst;
    logic [0:11][11:0] exp;
  } vec_t;
  vec_t vecs[5];

  function automatic int pattern(input int mode, input int x, input int y, input int k);
    case (mode)
      0: return (x + y) % 4096;
      1: begin
        if (y % 2 == 0) return (x % 2 == 0) ? 2048 : 4095;
        else            return (x % 2 == 0) ? 0 : 2048;
      end
      2: return ((((x / 16) % 2) ^ ((y / 16) % 2)) != 0) ? 4095 : 0;
      default: return k;
    endcase
  endfunction

  task automatic decode(input int pos, output bit fv, output bit lv, output int x, output int y);
    int t;
    fv = 0; lv = 0; x = 0; y = 0;
    if (pos < VB) return;
    fv = 1;
    t = pos - VB - LEAD;
    if (t < 0 || t >= ACT) return;
    y  = t / (W + HB);
    x  = t % (W + HB);
    lv = (x < W);
  endtask

  task automatic model_reset();
    m_edges = 0; m_run = 0; m_pos = 0; m_mode = 0; m_const = 0;
    m_fcount = 0; m_done = 0;
  endtask

  task automatic model_edge();
    m_done = 0;
    m_edges++;
    if (m_edges % 4 != 0) return;
    if (!m_run) begin
      if (iEnable) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == PERIOD - 1) begin
      m_done   = 1;
      m_fcount = (m_fcount + 1) % 65536;
      if (iEnable) m_pos = 0;
      else         m_run = 0;
    end else begin
      m_pos++;
      if (m_pos == VB) begin m_mode = iMode; m_const = iConst; end
    end
  endtask

  task automatic check(input string name);
    bit efv, elv, epix;
    int ex, ey, edata;
    efv = 0; elv = 0; ex = 0; ey = 0;
    if (m_run) decode(m_pos, efv, elv, ex, ey);
    edata = elv ? pattern(m_mode, ex, ey, m_const) : 0;
    epix  = (m_edges % 4) >= 2;
    tests++;
    if (oF_valid !== efv || oL_valid !== elv || oCam_data !== 12'(edata) ||
        oFrame_done !== m_done || oFrame_count !== 16'(m_fcount) || oPIXCLK !== epix) begin
      fails++;
      $display("FAIL %s t=%0t: got fv=%0b lv=%0b data=%0d done=%0b cnt=%0d pix=%0b, expected fv=%0b lv=%0b data=%0d done=%0b cnt=%0d pix=%0b",
               name, $time, oF_valid, oL_valid, oCam_data, oFrame_done, oFrame_count, oPIXCLK,
               efv, elv, edata, m_done, m_fcount, epix);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One iCLK: advance model at the active edge, compare on the falling edge.
  task automatic cyc();
    @(posedge iCLK);
    model_edge();
    @(negedge iCLK);
    check("cycle");
    if (m_edges % 4 == 0 && oL_valid) cap.push_back(oCam_data);
  endtask

  // Called at a falling edge; asserts reset asynchronously and checks it.
  task automatic do_reset();
    iRST = 1'b0;
    #1;
    model_reset();
    check("reset_async");
    repeat (3) begin
      @(posedge iCLK);
      @(negedge iCLK);
      check("reset_hold");
    end
    iRST = 1'b1;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (oFrame_done) begin ok = 1; break; end
    end
  endtask

  task automatic cmp_cap(input string tag, input int v);
    check_int($sformatf("%s_len", tag), cap.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < cap.size())
        check_int($sformatf("%s_px%0d", tag, i), int'(cap[i]), int'(vecs[v].exp[i]));
  endtask

  initial begin
    bit ok;
    int n, fvc, lvc, lvr, rises;
    bit prev, fv_seen;

    vecs[0] = '{mode: 2'd0, konst: 12'h000,
                exp: {12'd0, 12'd1, 12'd2, 12'd3, 12'd1, 12'd2, 12'd3, 12'd4, 12'd2, 12'd3, 12'd4, 12'd5}};
    vecs[1] = '{mode: 2'd1, konst: 12'h000,
                exp: {12'd2048, 12'd4095, 12'd2048, 12'd4095, 12'd0, 12'd2048, 12'd0, 12'd2048,
                      12'd2048, 12'd4095, 12'd2048, 12'd4095}};
    vecs[2] = '{mode: 2'd2, konst: 12'h123, exp: {12{12'd0}}};
    vecs[3] = '{mode: 2'd3, konst: 12'h5A5, exp: {12{12'h5A5}}};
    vecs[4] = '{mode: 2'd3, konst: 12'hFFF, exp: {12{12'hFFF}}};

    model_reset();
    do_reset();

    // Table: one complete frame per pattern record.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      iMode = vecs[v].mode; iConst = vecs[v].konst; iEnable = 1'b1;
      cap.delete();
      run_until_done(300, ok);
      check_int($sformatf("tbl%0d_done", v), int'(ok), 1);
      iEnable = 1'b0;
      cmp_cap($sformatf("tbl%0d", v), v);
    end

    // Frame timing in iCLK cycles.
    do_reset();
    iMode = 2'd0; iEnable = 1'b1;
    run_until_done(300, ok);
    check_int("timing_first_done", int'(ok), 1);
    n = 0; fvc = 0; lvc = 0; lvr = 0; prev = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(); n++;
      if (oF_valid) fvc++;
      if (oL_valid) lvc++;
      if (oL_valid && !prev) lvr++;
      prev = oL_valid;
      if (oFrame_done) break;
    end
    check_int("frame_period_clks", n, 84);
    check_int("fv_high_clks", fvc, 72);
    check_int("lv_high_clks", lvc, 48);
    check_int("lv_pulses", lvr, 3);

    // Stop request during line 1 lets the frame finish, then idles.
    do_reset();
    iMode = 2'd0; iEnable = 1'b1; rises = 0; prev = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (oL_valid && !prev) rises++;
      prev = oL_valid;
      if (rises == 2) break;
    end
    check_int("stop_reach_line1", rises, 2);
    iEnable = 1'b0;
    run_until_done(400, ok);
    check_int("stop_done", int'(ok), 1);
    check_int("stop_count", int'(oFrame_count), 1);
    fv_seen = 0;
    repeat (200) begin cyc(); if (oF_valid) fv_seen = 1; end
    check_int("stop_idle_fv", int'(fv_seen), 0);
    check_int("stop_count_hold", int'(oFrame_count), 1);

    // Mode change mid-frame only affects the following frame.
    do_reset();
    iMode = 2'd0; iConst = 12'h5A5; iEnable = 1'b1;
    cap.delete();
    for (int i = 0; i < 400; i++) begin cyc(); if (oL_valid) break; end
    iMode = 2'd3;
    run_until_done(400, ok);
    check_int("modechg_done1", int'(ok), 1);
    cmp_cap("modechg_ramp", 0);
    cap.delete();
    run_until_done(400, ok);
    check_int("modechg_done2", int'(ok), 1);
    cmp_cap("modechg_const", 3);
    iEnable = 1'b0;

    // Reset mid-line, then FV rise latency after release.
    do_reset();
    iMode = 2'd0; iEnable = 1'b1;
    for (int i = 0; i < 400; i++) begin cyc(); if (oL_valid) break; end
    check_int("rst_in_line", int'(oL_valid), 1);
    do_reset();
    check_int("rst_fv_zero", int'(oF_valid), 0);
    n = 0;
    for (int i = 0; i < 200; i++) begin cyc(); n++; if (oF_valid) break; end
    check_int("fv_rise_clks", n, 4 * (VB + 1));

    // Randomised run against the model.
    iEnable = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      do_reset();
      else if (r < 6)  iEnable = ~iEnable;
      else if (r < 12) iMode = 2'($urandom_range(0, 3));
      else             iConst = 12'($urandom);
      repeat ($urandom_range(1, 80)) cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ccd_pattern_source.md
CCD_PATTERN_SOURCE -- requirements
Module: ccd_pattern_source

Interface
REQ-001 Parameter ACTIVE_W, default 2592, active pixels per line.
REQ-002 Parameter ACTIVE_H, default 1944, active lines per frame.
REQ-003 Parameter H_BLANK, default 16, pixel times with LV low between lines.
REQ-004 Parameter V_BLANK, default 64, pixel times with FV low before each frame.
REQ-005 Parameter FV_LEAD, default 4, pixel times with FV high and LV low before the first line.
REQ-006 Parameter FV_TRAIL, default 4, pixel times with FV high and LV low after the last line.
REQ-007 iCLK  in  1  system clock.
REQ-008 iRST  in  1  reset; iRST is asynchronous and active-low.
REQ-009 iEnable  in  1  high: generate frames continuously; low: stop at the next frame boundary.
REQ-010 iMode  in  2  pattern: 0 ramp, 1 Bayer flat, 2 checkerboard, 3 constant.
REQ-011 iConst  in  12  value for mode 3.
REQ-012 oPIXCLK  out  1  pixel clock, iCLK/4.
REQ-013 oF_valid  out  1  FRAME_VALID.
REQ-014 oL_valid  out  1  LINE_VALID.
REQ-015 oCam_data  out  12  pixel data.
REQ-016 oFrame_done  out  1  one-iCLK pulse at the end of each frame.
REQ-017 oFrame_count  out  16  completed frames, wraps 65535->0.

Function
REQ-018 A 2-bit divider increments every iCLK; oPIXCLK = divider[1]; pixel tick = divider==3.
REQ-019 The FSM, counters and all pixel outputs update only on the iCLK edge where tick is high, so they are stable across the oPIXCLK rising edge.
REQ-020 States: IDLE, VBLANK, LEAD, LINE, HBLANK, TRAIL. Each state counts its own duration in ticks.
REQ-021 IDLE: FV=0, LV=0. On a tick with iEnable=1 -> VBLANK.
REQ-022 VBLANK: FV=0, LV=0 for V_BLANK ticks, then -> LEAD.
REQ-023 LEAD: FV=1, LV=0 for FV_LEAD ticks, then -> LINE with x=0, y=0.
REQ-024 LINE: FV=1, LV=1 for ACTIVE_W ticks; x increments per tick. After x=ACTIVE_W-1: -> HBLANK if y<ACTIVE_H-1, else -> TRAIL.
REQ-025 HBLANK: FV=1, LV=0 for H_BLANK ticks, then y+1, x=0 -> LINE.
REQ-026 TRAIL: FV=1, LV=0 for FV_TRAIL ticks. On exit: oFrame_done pulses for one iCLK, oFrame_count increments, and the FSM goes to VBLANK if iEnable=1, else to IDLE.
REQ-027 Frame length = V_BLANK+FV_LEAD+ACTIVE_H*ACTIVE_W+(ACTIVE_H-1)*H_BLANK+FV_TRAIL ticks.
REQ-028 iEnable falling mid-frame does not truncate the frame; the frame completes fully.
REQ-029 iMode and iConst are sampled at LEAD entry and held constant for the whole frame.
REQ-030 oCam_data = 0 whenever LV=0.
REQ-031 Mode 0 (ramp): data = (x+y) mod 4096.
REQ-032 Mode 1 (Bayer flat), selected by {y[0],x[0]}:
  - 00: G = 2048
  - 01: R = 4095
  - 10: B = 0
  - 11: G = 2048
REQ-033 Mode 2 (checkerboard): data = 4095 if x[4]^y[4], else 0.
REQ-034 Mode 3 (constant): data = the sampled iConst.
REQ-035 x and y are 16 bits wide; the ramp sum is 17 bits wide and truncated to 12 bits.
REQ-036 All outputs are registered.

Reset
REQ-037 While iRST=0:
  - divider=0, state=IDLE, x=0, y=0
  - oPIXCLK=0, oF_valid=0, oL_valid=0, oCam_data=0, oFrame_done=0, oFrame_count=0
REQ-038 Reset asserted mid-frame drops FV and LV immediately (asynchronously); generation restarts from IDLE.

Structure
REQ-039 A shared package ccd_pkg holds:
  - the state encoding
  - the mode constants (MODE_RAMP, MODE_BAYER, MODE_CHECKER, MODE_CONST)
  - the Bayer level constants
  - the default COLUMN_WIDTH = 2592
REQ-040 One sub-module, ccd_pattern_lut, performs the combinational pattern computation from (mode, x, y, const) to 12-bit data.

Verification
REQ-041 Timing: ACTIVE_W=4, ACTIVE_H=3, H_BLANK=2, V_BLANK=3, FV_LEAD=1, FV_TRAIL=1, iEnable=1 -> frame period 21 ticks (84 iCLK); FV high 18 ticks; three LV pulses of 4 ticks, separated by 2 ticks; oFrame_done pulses once per 84 iCLK.
REQ-042 Ramp: mode 0 with the REQ-041 parameters -> lines read 0,1,2,3 / 1,2,3,4 / 2,3,4,5; data is 0 outside LV.
REQ-043 Stop: iEnable deasserted during line 1 -> the frame completes, oFrame_count becomes 1, and the FSM holds IDLE with FV=0.
REQ-044 Bayer: mode 1 -> row 0 reads 2048,4095,2048,4095 and row 1 reads 0,2048,0,2048.
REQ-045 Mode change: iMode switched 0->3 (iConst=0x5A5) mid-frame -> the current frame stays ramp; the next frame is all 0x5A5.
REQ-046 Reset: iRST pulsed low mid-line -> all outputs are 0 within the same cycle; after release, FV rises V_BLANK+1 ticks later.
